// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Bundles the requester byte streams and the UART TX handshake that the
//   arbiter sits between. Signal suffixes are from the arbiter's viewpoint
//   (_i = into the arbiter, _o = out of the arbiter).
//
//   req_valid_i        [NUM_REQ]    per-requester byte valid
//   req_data_i         [8*NUM_REQ]  flat data, requester k on [8k+7:8k]
//   req_last_i         [NUM_REQ]    byte closes its packet
//   req_ready_o        [NUM_REQ]    byte accepted when valid & ready
//   grant_o            [NUM_REQ]    one-hot channel owner, 0 when free
//   uart_tx_data_o     [8]          to uart tx_data_i
//   uart_tx_trigger_o  [1]          to uart tx_trigger_i, one-cycle pulse
//   uart_tx_complete_i [1]          from uart tx_complete_o, high = idle
//   busy_o             [1]          arbiter not idle
//   err_o              [1]          start-timeout pulse
//
//   modport slave  : the arbiter
//   modport master : requesters + UART side (the environment)
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid_i;
    logic [8*NUM_REQ-1:0] req_data_i;
    logic [NUM_REQ-1:0]   req_last_i;
    logic [NUM_REQ-1:0]   req_ready_o;
    logic [NUM_REQ-1:0]   grant_o;
    logic [7:0]           uart_tx_data_o;
    logic                 uart_tx_trigger_o;
    logic                 uart_tx_complete_i;
    logic                 busy_o;
    logic                 err_o;

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, uart_tx_complete_i,
        output req_ready_o, grant_o, uart_tx_data_o, uart_tx_trigger_o,
               busy_o, err_o
    );

    modport master (
        output req_valid_i, req_data_i, req_last_i, uart_tx_complete_i,
        input  req_ready_o, grant_o, uart_tx_data_o, uart_tx_trigger_o,
               busy_o, err_o
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART TX channel between NUM_REQ byte-stream requesters.
//   Round-robin arbitration with packet locking: the owner keeps the channel
//   until it sends a byte flagged last, or leaves valid low for LOCK_TIMEOUT
//   cycles while the arbiter waits for its next byte.
//
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   bus     uart_tx_arbiter_if.slave (requester + UART handshake signals)
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int LOCK_TIMEOUT  = 1000,
    parameter int GAP_CYCLES    = 0,
    parameter int START_TIMEOUT = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    uart_tx_arbiter_if.slave   bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int LW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(START_TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, ACCEPT, TRIGGER, WAIT_START, WAIT_DONE, GAP
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant;
    logic [IW-1:0]        r_gidx, r_ptr;
    logic [7:0]           r_data;
    logic                 r_last, r_trig;
    logic [LW-1:0]        r_tocnt;
    logic [SW-1:0]        r_stcnt;
    logic [GW-1:0]        r_gapcnt;

    logic                 w_found;
    logic [IW-1:0]        w_win_idx, w_ptr_nxt;
    logic [NUM_REQ-1:0]   w_win_oh;
    logic [7:0]           w_req_data;
    logic                 w_grant, w_release, w_capture, w_err;
    logic                 w_to_clr, w_to_inc, w_st_clr, w_st_inc, w_gap_clr, w_gap_inc;

    // First valid requester at or above the pointer, wrapping.
    always_comb begin
        int j;
        w_found   = 1'b0;
        w_win_idx = '0;
        j         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(r_ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!w_found && bus.req_valid_i[IW'(j)]) begin
                w_found   = 1'b1;
                w_win_idx = IW'(j);
            end
        end
    end

    always_comb begin
        w_win_oh   = '0;
        w_req_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_win_oh[k] = (w_win_idx == IW'(k));
            if (r_gidx == IW'(k)) w_req_data = bus.req_data_i[8*k +: 8];
        end
    end

    // Releasing owner always hands priority to the next index: no starvation.
    assign w_ptr_nxt = (r_gidx == IW'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_release   = 1'b0;
        w_capture   = 1'b0;
        w_err       = 1'b0;
        w_to_clr    = 1'b0;
        w_to_inc    = 1'b0;
        w_st_clr    = 1'b0;
        w_st_inc    = 1'b0;
        w_gap_clr   = 1'b0;
        w_gap_inc   = 1'b0;
        case (r_state)
            // The UART has no reset and may still be mid-frame after ours.
            IDLE: if (bus.uart_tx_complete_i && w_found) begin
                w_grant     = 1'b1;
                w_to_clr    = 1'b1;
                w_state_nxt = ACCEPT;
            end
            ACCEPT: begin
                if (bus.req_valid_i[r_gidx]) begin
                    w_capture   = 1'b1;
                    w_state_nxt = TRIGGER;
                end else if (int'(r_tocnt) + 1 >= LOCK_TIMEOUT) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_to_inc    = 1'b1;
                end
            end
            TRIGGER: begin
                w_st_clr    = 1'b1;
                w_state_nxt = WAIT_START;
            end
            WAIT_START: begin
                if (!bus.uart_tx_complete_i) begin
                    w_state_nxt = WAIT_DONE;
                end else if (int'(r_stcnt) + 1 >= START_TIMEOUT) begin
                    // UART never started: byte presumed lost, carry on.
                    w_err       = 1'b1;
                    w_gap_clr   = 1'b1;
                    w_state_nxt = GAP;
                end else begin
                    w_st_inc    = 1'b1;
                end
            end
            WAIT_DONE: if (bus.uart_tx_complete_i) begin
                w_gap_clr   = 1'b1;
                w_state_nxt = GAP;
            end
            GAP: begin
                // GAP always lasts at least one cycle, GAP_CYCLES when > 0.
                if (int'(r_gapcnt) + 1 >= GAP_CYCLES) begin
                    if (r_last) begin
                        w_release   = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_to_clr    = 1'b1;
                        w_state_nxt = ACCEPT;
                    end
                end else begin
                    w_gap_inc = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_gidx   <= '0;
            r_ptr    <= '0;
            r_data   <= '0;
            r_last   <= 1'b0;
            r_trig   <= 1'b0;
            r_tocnt  <= '0;
            r_stcnt  <= '0;
            r_gapcnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_trig  <= (w_state_nxt == TRIGGER);
            if (w_grant) begin
                r_gidx  <= w_win_idx;
                r_grant <= w_win_oh;
            end
            if (w_release) begin
                r_grant <= '0;
                r_ptr   <= w_ptr_nxt;
            end
            // Data only moves on a handshake, so it holds across the frame.
            if (w_capture) begin
                r_data <= w_req_data;
                r_last <= bus.req_last_i[r_gidx];
            end
            if (w_to_clr)       r_tocnt  <= '0;
            else if (w_to_inc)  r_tocnt  <= r_tocnt + 1'b1;
            if (w_st_clr)       r_stcnt  <= '0;
            else if (w_st_inc)  r_stcnt  <= r_stcnt + 1'b1;
            if (w_gap_clr)      r_gapcnt <= '0;
            else if (w_gap_inc) r_gapcnt <= r_gapcnt + 1'b1;
        end
    end

    assign bus.req_ready_o       = (r_state == ACCEPT) ? r_grant : '0;
    assign bus.grant_o           = r_grant;
    assign bus.uart_tx_data_o    = r_data;
    assign bus.uart_tx_trigger_o = r_trig;
    assign bus.busy_o            = (r_state != IDLE);
    assign bus.err_o             = w_err;
endmodule
